// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: drives an external MAC through a multi-beat dot product.
// A command (mode, beat count) is accepted in IDLE. Operand beats are then
// streamed through the MAC, and each combinational MAC result is folded back
// into the accumulator. The final 24-bit sum is offered on a valid/ready
// result port. Illegal commands skip straight to a zero-valued error result.
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // Command port
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic [LEN_W-1:0] i_cmd_len,
  // Operand stream
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [255:0]     i_op_a,
  input  logic [255:0]     i_op_b,
  input  logic [7:0]       i_op_vsq_a,
  input  logic [7:0]       i_op_vsq_b,
  // Result port
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [23:0]      o_res_data,
  output logic             o_res_err,
  output logic             o_busy,
  // MAC side
  output logic [1:0]       o_mac_mode,
  output logic [23:0]      o_mac_psum,
  output logic [255:0]     o_mac_a,
  output logic [255:0]     o_mac_b,
  output logic [7:0]       o_mac_vsq_a,
  output logic [7:0]       o_mac_vsq_b,
  input  logic [23:0]      i_mac_result
);

  localparam int OP_W  = 256;
  localparam int ACC_W = 24;
  localparam int VSQ_W = 8;

  localparam logic [1:0]       MODE_ILLEGAL = 2'd3;
  localparam logic [LEN_W-1:0] CNT_ZERO     = '0;
  localparam logic [LEN_W-1:0] CNT_ONE      = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [1:0]         mode_q, mode_d;

  logic               cmd_hs;
  logic               op_hs;
  logic               res_hs;
  logic               run;

  // A command is usable only with a defined mode and at least one beat.
  function automatic logic cmd_is_legal(input logic [1:0]       mode,
                                        input logic [LEN_W-1:0] len);
    return (mode != MODE_ILLEGAL) && (len != CNT_ZERO);
  endfunction

  assign run    = (state_q == ST_RUN);
  assign cmd_hs = i_cmd_valid && o_cmd_ready;
  assign op_hs  = i_op_valid  && o_op_ready;
  assign res_hs = o_res_valid && i_res_ready;

  // Handshake readiness follows the state directly, so it is glitch-free
  // with respect to the other side's valid.
  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_op_ready  = run;
  assign o_res_valid = (state_q == ST_DONE);
  assign o_busy      = (state_q != ST_IDLE);

  // Result fields are only meaningful in DONE; keep them quiet elsewhere.
  assign o_res_data = o_res_valid ? acc_q : '0;
  assign o_res_err  = o_res_valid && err_q;

  // MAC operands are zeroed outside RUN so the datapath does not toggle
  // while the sequencer is idle or waiting on the result consumer.
  assign o_mac_mode  = mode_q;
  assign o_mac_psum  = acc_q;
  assign o_mac_a     = run ? i_op_a     : {OP_W{1'b0}};
  assign o_mac_b     = run ? i_op_b     : {OP_W{1'b0}};
  assign o_mac_vsq_a = run ? i_op_vsq_a : {VSQ_W{1'b0}};
  assign o_mac_vsq_b = run ? i_op_vsq_b : {VSQ_W{1'b0}};

  // Next-state logic: command latch, beat accumulation, result drain.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mode_d  = mode_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          mode_d = i_cmd_mode;
          acc_d  = '0;
          if (cmd_is_legal(i_cmd_mode, i_cmd_len)) begin
            cnt_d   = i_cmd_len;
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        // The counter is loaded with len >= 1 and leaves RUN on reaching
        // one, so it never decrements through zero even for the max length.
        if (op_hs) begin
          acc_d = i_mac_result;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (res_hs) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC closing the loop.
module tb_mac_seq_ctrl;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [255:0]     op_a;
  logic [255:0]     op_b;
  logic [7:0]       op_vsq_a;
  logic [7:0]       op_vsq_b;
  logic             res_valid;
  logic             res_ready;
  logic [23:0]      res_data;
  logic             res_err;
  logic             busy;
  logic [1:0]       mac_mode;
  logic [23:0]      mac_psum;
  logic [255:0]     mac_a;
  logic [255:0]     mac_b;
  logic [7:0]       mac_vsq_a;
  logic [7:0]       mac_vsq_b;
  logic [23:0]      mac_result;

  int n_assert = 0;
  int n_fail   = 0;

  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_mode   (cmd_mode),
    .i_cmd_len    (cmd_len),
    .i_op_valid   (op_valid),
    .o_op_ready   (op_ready),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .i_op_vsq_a   (op_vsq_a),
    .i_op_vsq_b   (op_vsq_b),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_data   (res_data),
    .o_res_err    (res_err),
    .o_busy       (busy),
    .o_mac_mode   (mac_mode),
    .o_mac_psum   (mac_psum),
    .o_mac_a      (mac_a),
    .o_mac_b      (mac_b),
    .o_mac_vsq_a  (mac_vsq_a),
    .o_mac_vsq_b  (mac_vsq_b),
    .i_mac_result (mac_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: signed lane products summed onto psum.
  // INT8: 32 byte lanes. INT4: 64 nibble lanes. INT4_VSQ: INT4 sum scaled by
  // (vsq_a * vsq_b) >> 8.
  function automatic logic [23:0] mac_model(input logic [1:0]   mode,
                                            input logic [23:0]  psum,
                                            input logic [255:0] a,
                                            input logic [255:0] b,
                                            input logic [7:0]   va,
                                            input logic [7:0]   vb);
    int sum;
    sum = 0;
    if (mode == 2'd0) begin
      for (int i = 0; i < 32; i++)
        sum += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    end else begin
      for (int i = 0; i < 64; i++)
        sum += int'($signed(a[4*i +: 4])) * int'($signed(b[4*i +: 4]));
      if (mode == 2'd2)
        sum = (sum * int'(va) * int'(vb)) >>> 8;
    end
    return psum + sum[23:0];
  endfunction

  always_comb mac_result = mac_model(mac_mode, mac_psum, mac_a, mac_b, mac_vsq_a, mac_vsq_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [23:0] exp_data, input logic exp_err);
    chk({tag, "_valid"}, 256'(res_valid), 256'(1'b1));
    chk({tag, "_data"},  256'(res_data),  256'(exp_data));
    chk({tag, "_err"},   256'(res_err),   256'(exp_err));
    chk({tag, "_noack"}, 256'(cmd_ready), 256'(1'b0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle"},  256'(cmd_ready), 256'(1'b1));
    chk({tag, "_vdrop"}, 256'(res_valid), 256'(1'b0));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_len   = '0;
    op_valid  = 1'b0;
    op_a      = {32{8'h5A}};
    op_b      = {32{8'hA5}};
    op_vsq_a  = 8'h11;
    op_vsq_b  = 8'h22;
    res_ready = 1'b0;

    // Reset state, including operand gating while IDLE
    tick();
    tick();
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1'b1));
    chk("rst_op_ready",  256'(op_ready),  256'(1'b0));
    chk("rst_res_valid", 256'(res_valid), 256'(1'b0));
    chk("rst_res_err",   256'(res_err),   256'(1'b0));
    chk("rst_busy",      256'(busy),      256'(1'b0));
    chk("rst_res_data",  256'(res_data),  256'(0));
    chk("rst_mac_psum",  256'(mac_psum),  256'(0));
    chk("rst_mac_mode",  256'(mac_mode),  256'(0));
    chk("rst_mac_a",     mac_a,           256'(0));
    chk("rst_mac_b",     mac_b,           256'(0));
    chk("rst_mac_vsq_a", 256'(mac_vsq_a), 256'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_gate_b",   mac_b,           256'(0));

    // INT8 len 1: 32 * (1*2) = 0x40, valid at T+2
    op_a = {32{8'h01}};
    op_b = {32{8'h02}};
    send_cmd(2'd0, 8'd1);
    chk("t1_busy",     256'(busy),      256'(1'b1));
    chk("t1_op_ready", 256'(op_ready),  256'(1'b1));
    chk("t1_cmd_rdy",  256'(cmd_ready), 256'(1'b0));
    chk("t1_mac_b",    mac_b,           {32{8'h02}});
    chk("t1_psum0",    256'(mac_psum),  256'(0));
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    take_result("t1", 24'h000040, 1'b0);

    // INT8 len 3 with two bubbles after beat 1: 0xC0, valid at T+6
    send_cmd(2'd0, 8'd3);
    chk("t2_psum_clr", 256'(mac_psum), 256'(0));
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    chk("t2_psum1", 256'(mac_psum), 256'(24'h40));
    tick();
    chk("t2_bub_b",     mac_b,           256'(0));
    chk("t2_bub_ready", 256'(op_ready),  256'(1'b1));
    chk("t2_bub_psum",  256'(mac_psum),  256'(24'h40));
    tick();
    op_a = {32{8'h01}};
    op_b = {32{8'h02}};
    op_valid = 1'b1;
    tick();
    chk("t2_mid_valid", 256'(res_valid), 256'(1'b0));
    chk("t2_psum2",     256'(mac_psum),  256'(24'h80));
    tick();
    op_valid = 1'b0;
    take_result("t2", 24'h0000C0, 1'b0);

    // INT4 len 2: nibbles -1 * 1 over 64 lanes = -64 per beat
    op_a = {64{4'hF}};
    op_b = {64{4'h1}};
    send_cmd(2'd1, 8'd2);
    chk("t3_mode", 256'(mac_mode), 256'(2'd1));
    op_valid = 1'b1;
    tick();
    chk("t3_psum1", 256'(mac_psum), 256'(24'hFFFFC0));
    tick();
    op_valid = 1'b0;
    take_result("t3", 24'hFFFF80, 1'b0);

    // INT4_VSQ len 1: 64 * (0x40*0x40 >> 8 = 0x10) = 0x400
    op_a     = {64{4'h1}};
    op_b     = {64{4'h1}};
    op_vsq_a = 8'h40;
    op_vsq_b = 8'h40;
    send_cmd(2'd2, 8'd1);
    chk("t4_vsq_a", 256'(mac_vsq_a), 256'(8'h40));
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("t4_vsq_gate", 256'(mac_vsq_b), 256'(0));
    take_result("t4", 24'h000400, 1'b0);

    // Illegal mode 3: error at T+1, held stable for 5 cycles, no beat taken
    op_valid = 1'b1;
    send_cmd(2'd3, 8'd4);
    chk("t5_op_ready", 256'(op_ready), 256'(1'b0));
    chk("t5_busy",     256'(busy),     256'(1'b1));
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_data", 256'(res_data),  256'(0));
      chk("t5_hold_err",  256'(res_err),   256'(1'b1));
      chk("t5_hold_cmd",  256'(cmd_ready), 256'(1'b0));
      tick();
    end
    op_valid = 1'b0;
    take_result("t5", 24'h000000, 1'b1);

    // Illegal length 0 in INT8
    send_cmd(2'd0, 8'd0);
    chk("t6_op_ready", 256'(op_ready), 256'(1'b0));
    take_result("t6", 24'h000000, 1'b1);

    // Maximum length 255 beats of 32 each: 0x1FE0, counter must not wrap
    op_a = {32{8'h01}};
    op_b = {32{8'h01}};
    send_cmd(2'd0, 8'd255);
    op_valid = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("t7_pre_valid", 256'(res_valid), 256'(1'b0));
    chk("t7_psum254",   256'(mac_psum),  256'(24'h001FC0));
    tick();
    op_valid = 1'b0;
    take_result("t7", 24'h001FE0, 1'b0);

    // Reset mid-RUN after 2 of 5 beats: asynchronous return to reset values
    op_b = {32{8'h02}};
    send_cmd(2'd0, 8'd5);
    op_valid = 1'b1;
    tick();
    tick();
    chk("t8_psum2", 256'(mac_psum), 256'(24'h80));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_rst_busy",  256'(busy),      256'(1'b0));
    chk("t8_rst_cmd",   256'(cmd_ready), 256'(1'b1));
    chk("t8_rst_opr",   256'(op_ready),  256'(1'b0));
    chk("t8_rst_psum",  256'(mac_psum),  256'(0));
    chk("t8_rst_mac_a", mac_a,           256'(0));
    chk("t8_rst_valid", 256'(res_valid), 256'(1'b0));
    op_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t8_post_valid", 256'(res_valid), 256'(1'b0));
    send_cmd(2'd0, 8'd1);
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    take_result("t8", 24'h000040, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer that owns one `mac` instance and drives it through a multi-beat dot product. It accepts a command (mode, beat count) and then consumes 256-bit operand beats over a valid/ready stream. On each accepted beat it feeds the beat and the running accumulator into the MAC and registers the MAC result back as the new accumulator. When the last beat is taken, it presents the final 24-bit sum on a valid/ready result port. It sits between the tile operand buffers and the output writeback.

## Interface
- `LEN_W`, 8: width of the command beat-count field; maximum length is 2^LEN_W−1 beats.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_cmd_valid`  in  1  command offered.
- `o_cmd_ready`  out  1  command accepted when high together with valid.
- `i_cmd_mode`  in  2  0 INT8, 1 INT4, 2 INT4_VSQ, 3 illegal.
- `i_cmd_len`  in  LEN_W  number of operand beats; 0 is illegal.
- `i_op_valid`  in  1  operand beat offered.
- `o_op_ready`  out  1  operand beat accepted when high together with valid.
- `i_op_a`, `i_op_b`  in  256 each  flattened vectors.
- `i_op_vsq_a`, `i_op_vsq_b`  in  8 each  per-beat VSQ scales; ignored outside INT4_VSQ.
- `o_res_valid`  out  1  result available.
- `i_res_ready`  in  1  result consumed when high together with valid.
- `o_res_data`  out  24  final accumulator (two's complement).
- `o_res_err`  out  1  command was illegal; `o_res_data` is 0.
- `o_busy`  out  1  state is not IDLE.
- MAC side: `o_mac_mode` out 2, `o_mac_psum` out 24, `o_mac_a`/`o_mac_b` out 256, `o_mac_vsq_a`/`o_mac_vsq_b` out 8, `i_mac_result` in 24 (combinational MAC result).

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** `o_cmd_ready`=1.
  - On command handshake, latch the mode and set the accumulator to 0.
  - Legal command (mode ≤ 2 and len ≥ 1): load the remaining-beat counter with len and go to RUN.
  - Illegal command: set the error flag and go directly to DONE.
- **RUN:** `o_op_ready`=1.
  - On operand handshake: acc ← `i_mac_result`, counter − 1.
  - When the counter reaches 0 on that handshake, go to DONE.
  - If `i_op_valid` is low, nothing changes and there is no timeout.
- **DONE:** `o_res_valid`=1, `o_res_data`=acc, `o_res_err`=error flag.
  - On result handshake, go to IDLE and clear the error flag.
  - The result is held stable until consumed.
- MAC drive:
  - `o_mac_mode` = latched mode.
  - `o_mac_psum` = acc.
  - `o_mac_a`, `o_mac_b`, `o_mac_vsq_a`, `o_mac_vsq_b` = the corresponding `i_op_*` signals when state is RUN; all zero otherwise (power gating).
- Arithmetic: the accumulator is exactly the MAC's 24-bit output; it wraps with no additional saturation in this block.
- Only one command is in flight at a time; `o_cmd_ready` is 0 in RUN and DONE.

## Timing
- Reset values: state IDLE, acc 0, counter 0, error flag 0, latched mode 0.
  - Outputs at reset: `o_cmd_ready`=1; `o_op_ready`, `o_res_valid`, `o_res_err`, `o_busy`=0; `o_res_data`=0; all `o_mac_*`=0.
- Latency with no operand bubbles:
  - Command handshake at cycle T.
  - Beats accepted at T+1 … T+len.
  - `o_res_valid` high at T+len+1.
  - Each bubble cycle adds one cycle.
- Illegal command handshake at cycle T: `o_res_valid` high at T+1.
- Result handshake at cycle R: `o_cmd_ready` high at R+1. There is no same-cycle command acceptance in DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to the reset values. The partial result is discarded and is never presented.
- A len of 2^LEN_W−1 completes normally; the counter never wraps.

## Test plan
- **INT8, len 1:** all bytes of a=0x01, b=0x02 → `o_res_data`=0x000040, err 0, valid at T+2.
- **INT8, len 3, same beats, with 2 bubble cycles between beats 1 and 2:** result 0x0000C0, valid at T+6; `o_mac_b`=0 during the bubbles.
- **INT4, len 2:** a nibbles 0xF, b nibbles 0x1 → each beat −64; result 0xFFFF80.
- **INT4_VSQ, len 1:** a and b nibbles 0x1, vsq_a=vsq_b=0x40 → scale 0x10; result 0x000400.
- **Illegal commands:**
  - mode 3, len 4 → valid at T+1, err 1, data 0, no operand accepted.
  - len 0 in INT8 → same response.
  - `i_res_ready` held low for 5 cycles → data and err stay stable, `o_cmd_ready` stays 0.
- **Reset mid-RUN:** deassert `i_rst_n` after 2 of 5 beats → all outputs return to their reset values asynchronously. A fresh INT8 len 1 command afterwards yields 0x000040.
